cpu_clk_ctrl: RTL

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl - CPU clock-enable generator.
// Produces single-cycle clk_en pulses for a CPU in four modes: halt, fast run,
// slow run and single-step driven by a (possibly bouncy) pushbutton.
// Optional feature macro: CPU_CLK_CTRL_DEBOUNCE_EN
//   defined   : the step button level is debounced over DEB_CYCLES stable cycles
//   undefined : the synchronized button level is used directly
// No valid/ready handshakes: every input is a level sampled each clk cycle and
// clk_en is a one-cycle strobe with no back-pressure.
// dbg_state exposes the FSM state encoding (HALT=0, RUN=1, STEP_ARM=2, STEP_HOLD=3).
module cpu_clk_ctrl #(
  parameter int unsigned FAST_DIV_LOG2 = 18,
  parameter int unsigned SLOW_DIV_LOG2 = 25,
  parameter int unsigned DEB_CYCLES    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  output logic        clk_en,
  output logic [15:0] tick_cnt,
  output logic        running,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_HALT      = 2'd0,
    S_RUN       = 2'd1,
    S_STEP_ARM  = 2'd2,
    S_STEP_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_FAST = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;

  // Low-bit masks of the prescaler; computed in 64 bits so a divider of 32 works.
  localparam logic [31:0] FAST_MASK = 32'((64'd1 << FAST_DIV_LOG2) - 64'd1);
  localparam logic [31:0] SLOW_MASK = 32'((64'd1 << SLOW_DIV_LOG2) - 64'd1);

  logic [31:0] r_presc;
  logic [1:0]  r_mode_q;
  state_t      r_state;
  state_t      w_state_next;
  logic        r_clk_en;
  logic        w_clk_en_next;
  logic [15:0] r_tick_cnt;
  logic        r_running;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_filt;
  logic        r_filt_prev;
  logic        w_filt_rise;
  logic        w_tick;

  // Registered mode and free-running prescaler; a mode change restarts the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q <= MODE_HALT;
      r_presc  <= '0;
    end else begin
      r_mode_q <= mode;
      if (mode != r_mode_q) r_presc <= '0;
      else                  r_presc <= r_presc + 32'd1;
    end
  end

  // A tick is the last cycle of a period: all low divider bits are ones.
  assign w_tick = ((r_mode_q == MODE_FAST) && ((r_presc | ~FAST_MASK) == '1)) ||
                  ((r_mode_q == MODE_SLOW) && ((r_presc | ~SLOW_MASK) == '1));

  // Two-flop synchronizer for the asynchronous step button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  logic        r_filt;
  logic [15:0] r_deb_cnt;

  // Debounce: accept a new level only after DEB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt    <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_filt    <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 16'd1;
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  // Previous filtered level, used to find the press (0->1) edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_filt_prev <= 1'b0;
    else     r_filt_prev <= w_filt;
  end

  assign w_filt_rise = w_filt & ~r_filt_prev;

  // Next-state and next clk_en decode; mode_q selects the target state family.
  always_comb begin
    w_state_next  = r_state;
    w_clk_en_next = 1'b0;
    case (r_mode_q)
      MODE_HALT: w_state_next = S_HALT;
      MODE_FAST, MODE_SLOW: begin
        w_state_next  = S_RUN;
        w_clk_en_next = (r_state == S_RUN) && w_tick;
      end
      default: begin
        case (r_state)
          S_STEP_ARM: begin
            if (w_filt_rise) begin
              w_state_next  = S_STEP_HOLD;
              w_clk_en_next = 1'b1;
            end
          end
          S_STEP_HOLD: begin
            if (!w_filt) w_state_next = S_STEP_ARM;
          end
          default: w_state_next = S_STEP_ARM;
        endcase
      end
    endcase
  end

  // State register plus registered clk_en and running strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_HALT;
      r_clk_en  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_en  <= w_clk_en_next;
      r_running <= (w_state_next == S_RUN);
    end
  end

  // Count every cycle clk_en is high; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tick_cnt <= '0;
    else     r_tick_cnt <= r_tick_cnt + {15'd0, r_clk_en};
  end

  assign clk_en    = r_clk_en;
  assign tick_cnt  = r_tick_cnt;
  assign running   = r_running;
  assign dbg_state = r_state;

endmodule
